// File: rtl/store_queue.sv
// store_queue: circular store queue with store-to-load forwarding and in-order dcache drain
module store_queue #(
  parameter int SQ_SZ = 8,
  localparam int STOREQ_IDX = $clog2(SQ_SZ),
  localparam int EXECUTE_STOREQ_ENTRY = 65 + STOREQ_IDX
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            alloc_valid,
  output logic [STOREQ_IDX-1:0]           alloc_idx,
  output logic                            sq_full,
  output logic                            sq_empty,
  input  logic [EXECUTE_STOREQ_ENTRY-1:0] exec_entry,
  input  logic                            lookup_valid,
  input  logic [31:0]                     lookup_addr,
  input  logic [STOREQ_IDX-1:0]           lookup_sq_tail,
  output logic                            forward_valid,
  output logic [31:0]                     forward_data,
  output logic                            forward_stall,
  input  logic                            commit_valid,
  input  logic                            flush,
  output logic                            dc_store_valid,
  output logic [31:0]                     dc_store_addr,
  output logic [31:0]                     dc_store_data,
  input  logic                            dc_store_accept
);
  localparam int IW = STOREQ_IDX;
  logic [IW:0] head, tail, commit_ptr, commit_next;
  logic [SQ_SZ-1:0] executed;
  logic [29:0] addr_q [SQ_SZ];
  logic [31:0] data_q [SQ_SZ];
  logic [IW-1:0] head_idx, scan_cnt, scan_idx, ex_idx;
  logic [29:0] ex_word;
  logic [31:0] ex_data;
  logic ex_valid, do_alloc, do_commit, do_pop, unused;
  assign ex_valid = exec_entry[EXECUTE_STOREQ_ENTRY-1];
  assign ex_word = exec_entry[IW+63:IW+34];
  assign ex_data = exec_entry[IW+31:IW];
  assign ex_idx = exec_entry[IW-1:0];
  assign unused = ^{exec_entry[IW+33:IW+32], lookup_addr[1:0]};
  assign head_idx = head[IW-1:0];
  assign alloc_idx = tail[IW-1:0];
  assign sq_full = head[IW-1:0] == tail[IW-1:0] && head[IW] != tail[IW];
  assign sq_empty = head == tail;
  assign dc_store_valid = head != commit_ptr && executed[head_idx];
  assign dc_store_addr = dc_store_valid ? {addr_q[head_idx], 2'b00} : '0;
  assign dc_store_data = dc_store_valid ? data_q[head_idx] : '0;
  assign do_alloc = alloc_valid && !sq_full && !flush;
  assign do_commit = commit_valid && commit_ptr != tail;
  assign do_pop = dc_store_accept && dc_store_valid;
  assign commit_next = commit_ptr + {{IW{1'b0}}, do_commit};
  // pointers and executed flags; a flush keeps everything up to the newest committed store
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      commit_ptr <= '0;
      executed <= '0;
    end else begin
      head <= head + {{IW{1'b0}}, do_pop};
      commit_ptr <= commit_next;
      tail <= flush ? commit_next : tail + {{IW{1'b0}}, do_alloc};
      if (ex_valid) executed[ex_idx] <= 1'b1;
      if (do_alloc) executed[alloc_idx] <= 1'b0;
    end
  end
  // payload capture; unreset because every read is gated by the executed flag
  always_ff @(posedge clock) begin
    if (ex_valid) begin
      addr_q[ex_idx] <= ex_word;
      data_q[ex_idx] <= ex_data;
    end
  end
  // forwarding scan oldest to youngest so the youngest deciding entry overrides the rest
  always_comb begin
    forward_valid = 1'b0;
    forward_stall = 1'b0;
    forward_data = '0;
    scan_cnt = lookup_sq_tail - head_idx;
    scan_idx = head_idx;
    for (int k = 0; k < SQ_SZ; k++) begin
      scan_idx = head_idx + k[IW-1:0];
      if (lookup_valid && k < int'(scan_cnt)) begin
        if (!executed[scan_idx]) begin
          forward_stall = 1'b1;
          forward_valid = 1'b0;
          forward_data = '0;
        end else if (addr_q[scan_idx] == lookup_addr[31:2]) begin
          forward_stall = 1'b0;
          forward_valid = 1'b1;
          forward_data = data_q[scan_idx];
        end
      end
    end
  end
endmodule

// File: doc/store_queue.md
# store_queue

Circular store queue between dispatch, the memory functional unit and the data cache. It allocates one entry per dispatched store and captures the address/data computed by the memory FU at execute. It answers the FU's same-cycle store-to-load forwarding lookup, and drains ROB-committed stores in program order to the dcache write port. A branch-mispredict flush removes all uncommitted stores.

## Interface
Parameters:
- `SQ_SZ`, 8: number of entries (power of two); `STOREQ_IDX` is `$clog2(SQ_SZ)` bits.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `alloc_valid` in 1: dispatch allocates one store this cycle.
- `alloc_idx` out STOREQ_IDX: current tail index; dispatch tags the store with it.
- `sq_full` out 1: no free entry; dispatch must not allocate.
- `sq_empty` out 1: no valid entries.
- `exec_entry` in EXECUTE_STOREQ_ENTRY: {valid, addr[31:0], data[31:0], store_queue_idx} from the memory FU.
- `lookup_valid` in 1: a load requests forwarding.
- `lookup_addr` in 32: load byte address.
- `lookup_sq_tail` in STOREQ_IDX: tail index captured at load dispatch. Entries from head up to but excluding this index are older than the load.
- `forward_valid` out 1: forwarded data is valid.
- `forward_data` out 32: forwarded word.
- `forward_stall` out 1: an older store's address is still unknown; the load must wait.
- `commit_valid` in 1: the ROB retires the oldest uncommitted store.
- `flush` in 1: mispredict; discard uncommitted entries.
- `dc_store_valid` out 1: head store is ready to write the dcache.
- `dc_store_addr` out 32: word-aligned write address.
- `dc_store_data` out 32: write data.
- `dc_store_accept` in 1: dcache accepts the write; the head pops.

## Operation
- State:
  - `head` and `tail` pointers of STOREQ_IDX+1 bits; the MSB is the wrap bit.
  - `commit_ptr`, also with a wrap bit, marks the first uncommitted entry.
  - Per entry: `executed`, `addr`, `data`.
- Full when `head` and `tail` have equal index bits and differing wrap bits. Empty when all bits are equal. `sq_full`/`sq_empty` are derived from registered pointers only.
- Alloc:
  - If `alloc_valid && !sq_full && !flush`: clear `executed` at `tail`, then `tail++`.
  - Alloc while full is ignored, with no state change.
- Execute:
  - If `exec_entry.valid`: write `addr`/`data` at `store_queue_idx` and set `executed`.
  - Stores are word-granular. Only `addr[31:2]` is used for matching; `dc_store_addr` = {addr[31:2], 2'b00}.
- Commit: if `commit_valid` and `commit_ptr != tail`, then `commit_ptr++`. Otherwise the commit is ignored.
- Drain:
  - `dc_store_valid` = (`head != commit_ptr`) && `executed[head]`, driving the head entry's addr/data.
  - On `dc_store_accept && dc_store_valid`, `head++`.
- Flush: `tail` <= `commit_ptr`. Committed entries and the drain continue unaffected. `alloc_valid` in the same cycle is dropped.
- Forwarding is combinational from registered state, with no bypass of the same-cycle `exec_entry`:
  - Scan entries from `lookup_sq_tail-1` back toward `head`, youngest first.
  - At the first entry that is unexecuted: `forward_stall`=1, `forward_valid`=0.
  - At the first executed entry whose `addr[31:2]` equals `lookup_addr[31:2]`: `forward_valid`=1 and `forward_data` = that entry's data.
  - If the scan reaches `head` with no hit, all forwarding outputs are 0.
  - When `lookup_valid`=0, all forwarding outputs are 0.
- Simultaneous events:
  - Alloc, execute, commit, pop and flush may all occur in one cycle.
  - Pop frees an entry only for the next cycle: a full queue with a same-cycle pop still rejects alloc.
  - An execute write to an entry that a flush removes in the same cycle is harmless.

## Timing
- Reset values:
  - `head`=`tail`=`commit_ptr`=0 and all `executed`=0.
  - `alloc_idx`=0, `sq_full`=0, `sq_empty`=1.
  - `forward_valid`/`forward_stall`/`forward_data`=0.
  - `dc_store_valid`=0, `dc_store_addr`=0, `dc_store_data`=0.
- Reset mid-drain drops the in-flight store; `dc_store_valid` is low in the cycle after reset.
- Latencies:
  - Alloc is visible at `alloc_idx`/`sq_full` one cycle later.
  - An executed entry is visible to forwarding and drain one cycle after `exec_entry.valid`.
  - Forwarding responds in the same cycle as the lookup.
  - The earliest drain is the cycle after both commit and execute have occurred.
- `dc_store_valid` may remain high for multiple cycles with stable addr/data until accepted.

## Test plan
- Reset, then allocate 8 stores with no pops: `alloc_idx` reads 0..7, `sq_full`=1 after the 8th, and a 9th `alloc_valid` leaves `tail` unchanged.
- Store at idx0 executes addr 0x100 data 0xDEADBEEF. The next cycle, a lookup with addr 0x102 and sq_tail 1 gives `forward_valid`=1, data 0xDEADBEEF, `forward_stall`=0.
- Idx0 executed at 0x100, idx1 allocated but unexecuted, lookup addr 0x100 with sq_tail 2: `forward_stall`=1, `forward_valid`=0. After idx1 executes at 0x200, the same lookup forwards idx0's data.
- Idx0 and idx1 both at 0x40 with data 1 and 2, lookup with sq_tail 2: data 2 (youngest wins). The same lookup with sq_tail 1: data 1.
- Allocate 3 stores, execute all, commit 1, flush: `tail` returns to 1. Idx0 drains to the dcache with `dc_store_valid` held high across 2 cycles of `dc_store_accept`=0, pops on accept, then `sq_empty`=1.
- Fill to full with head at idx6 so the queue wraps, then execute/commit/accept continuously: stores drain in order 6,7,0,1,…, and alloc with a same-cycle pop while full is rejected.
